compare_feed: RTL and testbench

COMPARE_FEED -- requirements
Module: compare_feed

---
 rtl/compare_feed.sv | 198 +++++++++++++++++++
 tb/tb_compare_feed.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/compare_feed.sv
// ============================================================================
// Module   : compare_feed
// Purpose  : Feeds signed operand pairs from a producer to an external
//            combinational comparator and returns the registered comparison
//            result to a consumer over a valid/ready handshake.
//            Pairs are buffered in a 2-entry FIFO; a small FSM pops one pair,
//            holds it on the comparator inputs for one cycle, captures the
//            comparator output and presents it until the consumer accepts.
// Revision : 1.0 - initial release
//
// Ports
//   i_clk        in   1     clock, rising-edge active
//   i_rsn        in   1     asynchronous active-low reset
//   i_arg_A      in   BITS  operand A from producer (signed)
//   i_arg_B      in   BITS  operand B from producer (signed)
//   i_valid      in   1     producer offers an operand pair
//   o_ready      out  1     FIFO has room for a pair this cycle
//   o_arg_A      out  BITS  registered operand A to comparator (signed)
//   o_arg_B      out  BITS  registered operand B to comparator (signed)
//   i_cmp_result in   1     comparator result for o_arg_A / o_arg_B
//   o_result     out  1     registered comparison result
//   o_valid      out  1     o_result is valid for the consumer
//   i_ready      in   1     consumer accepts o_result
//   o_count      out  16    results delivered so far, wraps silently
// ============================================================================
`default_nettype none

module compare_feed #(
  parameter int BITS = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rsn,
  input  logic signed [BITS-1:0] i_arg_A,
  input  logic signed [BITS-1:0] i_arg_B,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic signed [BITS-1:0] o_arg_A,
  output logic signed [BITS-1:0] o_arg_B,
  input  logic                   i_cmp_result,
  output logic                   o_result,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [15:0]            o_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // 2-entry FIFO storage; A and B of a pair share one slot so they can
  // never be separated or reordered.
  logic signed [BITS-1:0] fifo_a [2];
  logic signed [BITS-1:0] fifo_b [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             fill;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic capture;
  logic deliver;

  logic [15:0] count;

  assign fifo_empty = (fill == 2'd0);
  assign fifo_full  = (fill == 2'd2);

  // Ready depends on occupancy only, never on the consumer side.
  assign o_ready = ~fifo_full;
  assign push    = i_valid & ~fifo_full;
  assign o_count = count;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and control strobes.
  // Pop decisions use the occupancy before this edge, so a pair pushed on
  // the same edge is never popped at once (no bypass path).
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    deliver   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        // Operands have been stable on the comparator for a full cycle.
        capture   = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_ready) begin
          deliver = 1'b1;
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = ST_SAMPLE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO storage and pointers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      for (int i = 0; i < 2; i++) begin
        fifo_a[i] <= '0;
        fifo_b[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      fill   <= 2'd0;
    end else begin
      if (push) begin
        fifo_a[wr_ptr] <= i_arg_A;
        fifo_b[wr_ptr] <= i_arg_B;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   fill <= fill + 2'd1;
        2'b01:   fill <= fill - 2'd1;
        default: fill <= fill;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Comparator operand registers: only change when a pair is popped, so
  // they hold their last values while idle and stay stable while a result
  // is sampled or waiting.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      o_arg_A <= '0;
      o_arg_B <= '0;
    end else if (pop) begin
      o_arg_A <= fifo_a[rd_ptr];
      o_arg_B <= fifo_b[rd_ptr];
    end
  end

  // --------------------------------------------------------------------------
  // Result, valid and delivery counter
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      o_result <= 1'b0;
      o_valid  <= 1'b0;
      count    <= 16'h0000;
    end else begin
      if (capture) begin
        o_result <= i_cmp_result;
        o_valid  <= 1'b1;
      end else if (deliver) begin
        o_valid  <= 1'b0;
      end
      if (deliver) begin
        count <= count + 16'h0001;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_compare_feed.sv
// ============================================================================
// Module   : tb_compare_feed
// Purpose  : Directed self-checking bench for compare_feed. A behavioural
//            signed greater-than comparator closes the loop from o_arg_A /
//            o_arg_B back to i_cmp_result. Inputs are driven on the falling
//            edge and outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_compare_feed;

  localparam int BITS = 32;

  logic                   i_clk;
  logic                   i_rsn;
  logic signed [BITS-1:0] i_arg_A;
  logic signed [BITS-1:0] i_arg_B;
  logic                   i_valid;
  logic                   o_ready;
  logic signed [BITS-1:0] o_arg_A;
  logic signed [BITS-1:0] o_arg_B;
  logic                   i_cmp_result;
  logic                   o_result;
  logic                   o_valid;
  logic                   i_ready;
  logic [15:0]            o_count;

  int vectors;
  int miscompares;

  compare_feed #(.BITS(BITS)) dut (
    .i_clk        (i_clk),
    .i_rsn        (i_rsn),
    .i_arg_A      (i_arg_A),
    .i_arg_B      (i_arg_B),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_arg_A      (o_arg_A),
    .o_arg_B      (o_arg_B),
    .i_cmp_result (i_cmp_result),
    .o_result     (o_result),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_count      (o_count)
  );

  // External comparator: signed A > B.
  assign i_cmp_result = (o_arg_A > o_arg_B);

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rsn   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_arg_A = '0;
    i_arg_B = '0;
    tick();
    tick();
    i_rsn = 1'b1;
  endtask

  task automatic drive(input logic v, input int a, input int b);
    i_valid = v;
    i_arg_A = a;
    i_arg_B = b;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    i_rsn = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_arg_A = '0; i_arg_B = '0;
    tick();
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", o_valid); end
    vectors++; if (o_result !== 1'b0) begin miscompares++; $display("FAIL rst_result: got %b want 0", o_result); end
    vectors++; if (o_count !== 16'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", o_count); end
    vectors++; if (o_arg_A !== 0 || o_arg_B !== 0) begin miscompares++; $display("FAIL rst_args: got %0d/%0d want 0/0", o_arg_A, o_arg_B); end
    i_rsn = 1'b1;
    tick();
    vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", o_ready); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_single();
    do_reset();
    i_ready = 1'b1;
    drive(1'b1, 5, -3);
    tick();                 // edge t: push
    drive(1'b0, 0, 0);
    vectors++; if (o_arg_A !== 0 || o_valid !== 1'b0) begin miscompares++; $display("FAIL single_nobypass: got A=%0d v=%b want A=0 v=0", o_arg_A, o_valid); end
    tick();                 // edge t+1: pop
    vectors++; if (o_arg_A !== 5 || o_arg_B !== -3) begin miscompares++; $display("FAIL single_args: got %0d/%0d want 5/-3", o_arg_A, o_arg_B); end
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid: got %b want 0", o_valid); end
    tick();                 // edge t+2: sample
    vectors++; if (o_valid !== 1'b1 || o_result !== 1'b1) begin miscompares++; $display("FAIL single_result: got v=%b r=%b want v=1 r=1", o_valid, o_result); end
    tick();                 // edge t+3: delivered
    vectors++; if (o_valid !== 1'b0 || o_count !== 16'd1) begin miscompares++; $display("FAIL single_count: got v=%b cnt=%0d want v=0 cnt=1", o_valid, o_count); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure();
    do_reset();
    i_ready = 1'b0;
    drive(1'b1, 0, -1);  tick();   // e1: push P1
    drive(1'b1, 7, -8);  tick();   // e2: push P2, pop P1
    drive(1'b1, 3, 3);   tick();   // e3: push P3 -> full, result of P1 valid
    vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full: got ready=%b want 0", o_ready); end
    // Offer a fourth pair while full and consumer stalled.
    drive(1'b1, 100, 1);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (o_valid !== 1'b1 || o_result !== 1'b1 || o_ready !== 1'b0 || o_arg_A !== 0) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got v=%b r=%b rdy=%b A=%0d want v=1 r=1 rdy=0 A=0", i, o_valid, o_result, o_ready, o_arg_A);
      end
      tick();
    end
    drive(1'b0, 0, 0);
    i_ready = 1'b1;
    tick();                          // deliver P1, pop P2
    vectors++; if (o_arg_A !== 7 || o_arg_B !== -8 || o_count !== 16'd1 || o_valid !== 1'b0) begin miscompares++; $display("FAIL bp_pop2: got A=%0d B=%0d cnt=%0d v=%b want 7/-8 cnt=1 v=0", o_arg_A, o_arg_B, o_count, o_valid); end
    tick();
    vectors++; if (o_valid !== 1'b1 || o_result !== 1'b1) begin miscompares++; $display("FAIL bp_res2: got v=%b r=%b want v=1 r=1", o_valid, o_result); end
    tick();                          // deliver P2, pop P3
    vectors++; if (o_arg_A !== 3 || o_arg_B !== 3) begin miscompares++; $display("FAIL bp_pop3: got %0d/%0d want 3/3", o_arg_A, o_arg_B); end
    tick();
    vectors++; if (o_valid !== 1'b1 || o_result !== 1'b0) begin miscompares++; $display("FAIL bp_res3: got v=%b r=%b want v=1 r=0", o_valid, o_result); end
    tick();                          // deliver P3, go idle
    tick();
    tick();
    vectors++; if (o_valid !== 1'b0 || o_count !== 16'd3 || o_arg_A !== 3) begin miscompares++; $display("FAIL bp_end: got v=%b cnt=%0d A=%0d want v=0 cnt=3 A=3 (ignored pair absent)", o_valid, o_count, o_arg_A); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_streaming();
    logic signed [BITS-1:0] sa [10];
    logic signed [BITS-1:0] sb [10];
    logic                   se [10];
    int k, r, cyc, last;
    logic acc;
    sa = '{32'sd1, 32'sd0, -32'sd5, -32'sd6, 32'sd100, 32'sh7FFFFFFF, 32'sh80000000, -32'sd1, 32'sd0, 32'sd2};
    sb = '{32'sd0, 32'sd1, -32'sd6, -32'sd5, 32'sd100, 32'sh80000000, 32'sh7FFFFFFF, 32'sd0, -32'sd1, 32'sd1};
    se = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    i_ready = 1'b1;
    k = 0; r = 0; cyc = 0; last = 0;
    while (r < 10 && cyc < 200) begin
      if (o_valid) begin
        vectors++;
        if (o_result !== se[r] || o_arg_A !== sa[r] || o_arg_B !== sb[r]) begin
          miscompares++;
          $display("FAIL stream_res%0d: got r=%b A=%0d B=%0d want r=%b A=%0d B=%0d", r, o_result, o_arg_A, o_arg_B, se[r], sa[r], sb[r]);
        end
        if (r > 0) begin
          vectors++;
          if (cyc - last != 2) begin miscompares++; $display("FAIL stream_gap%0d: got %0d cycles want 2", r, cyc - last); end
        end
        last = cyc;
        r++;
      end
      if (r >= 10) break;
      if (k < 10) begin
        drive(1'b1, sa[k], sb[k]);
        acc = o_ready;
      end else begin
        drive(1'b0, 0, 0);
        acc = 1'b0;
      end
      tick();
      if (acc) k++;
      cyc++;
    end
    drive(1'b0, 0, 0);
    vectors++; if (r != 10) begin miscompares++; $display("FAIL stream_timeout: got %0d results want 10", r); end
    tick();
    vectors++; if (o_count !== 16'd10 || o_valid !== 1'b0) begin miscompares++; $display("FAIL stream_count: got cnt=%0d v=%b want cnt=10 v=0", o_count, o_valid); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_wrap();
    do_reset();
    force dut.count = 16'hFFFF;
    tick();
    release dut.count;
    i_ready = 1'b1;
    drive(1'b1, 1, 2); tick();
    drive(1'b0, 0, 0);
    tick(); tick();
    vectors++; if (o_valid !== 1'b1 || o_result !== 1'b0) begin miscompares++; $display("FAIL wrap_res: got v=%b r=%b want v=1 r=0", o_valid, o_result); end
    tick();
    vectors++; if (o_count !== 16'h0000) begin miscompares++; $display("FAIL wrap_count: got %h want 0000", o_count); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid();
    do_reset();
    i_ready = 1'b0;
    drive(1'b1, 9, 2);   tick();
    drive(1'b1, 4, 1);   tick();
    drive(1'b1, 6, -6);  tick();     // WAIT, valid=1, two pairs queued
    drive(1'b0, 0, 0);
    vectors++; if (o_valid !== 1'b1 || o_result !== 1'b1 || o_ready !== 1'b0) begin miscompares++; $display("FAIL mid_setup: got v=%b r=%b rdy=%b want 1/1/0", o_valid, o_result, o_ready); end
    #2 i_rsn = 1'b0;
    #1;
    vectors++;
    if (o_valid !== 1'b0 || o_result !== 1'b0 || o_arg_A !== 0 || o_arg_B !== 0 || o_count !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_async: got v=%b r=%b A=%0d B=%0d cnt=%0d want all 0", o_valid, o_result, o_arg_A, o_arg_B, o_count);
    end
    tick();
    i_rsn = 1'b1;
    i_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (o_valid !== 1'b0 || o_arg_A !== 0 || o_count !== 16'd0 || o_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL mid_stale%0d: got v=%b A=%0d cnt=%0d rdy=%b want 0/0/0/1", i, o_valid, o_arg_A, o_count, o_ready);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_simul_push_pop();
    do_reset();
    i_ready = 1'b0;
    drive(1'b1, 4, 9);    tick();    // e1 push P1
    drive(1'b1, -2, -7);  tick();    // e2 push P2, pop P1
    drive(1'b0, 0, 0);    tick();    // e3 SAMPLE -> WAIT
    vectors++; if (o_valid !== 1'b1 || o_result !== 1'b0 || o_ready !== 1'b1) begin miscompares++; $display("FAIL sim_setup: got v=%b r=%b rdy=%b want 1/0/1", o_valid, o_result, o_ready); end
    i_ready = 1'b1;
    drive(1'b1, 11, 11);  tick();    // e4 push P3 + pop P2
    vectors++; if (o_arg_A !== -2 || o_arg_B !== -7 || o_count !== 16'd1 || o_ready !== 1'b1) begin miscompares++; $display("FAIL sim_pushpop: got A=%0d B=%0d cnt=%0d rdy=%b want -2/-7 cnt=1 rdy=1", o_arg_A, o_arg_B, o_count, o_ready); end
    drive(1'b1, 20, -20); tick();    // e5 push P4 -> full (occupancy was 1)
    drive(1'b0, 0, 0);
    vectors++; if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_result !== 1'b1) begin miscompares++; $display("FAIL sim_full: got rdy=%b v=%b r=%b want 0/1/1", o_ready, o_valid, o_result); end
    tick();                          // e6 pop P3
    vectors++; if (o_arg_A !== 11 || o_arg_B !== 11 || o_ready !== 1'b1) begin miscompares++; $display("FAIL sim_order3: got %0d/%0d rdy=%b want 11/11 rdy=1", o_arg_A, o_arg_B, o_ready); end
    tick();
    vectors++; if (o_valid !== 1'b1 || o_result !== 1'b0) begin miscompares++; $display("FAIL sim_res3: got v=%b r=%b want 1/0", o_valid, o_result); end
    tick();                          // e8 pop P4
    vectors++; if (o_arg_A !== 20 || o_arg_B !== -20) begin miscompares++; $display("FAIL sim_order4: got %0d/%0d want 20/-20", o_arg_A, o_arg_B); end
    tick();
    tick();
    vectors++; if (o_count !== 16'd4 || o_valid !== 1'b0) begin miscompares++; $display("FAIL sim_count: got cnt=%0d v=%b want 4/0", o_count, o_valid); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_wrap();
    test_reset_mid();
    test_simul_push_pop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
